// File: rtl/md5_hex_parser.sv
// md5_hex_parser: parses keyboard hex characters into a 128-bit MD5 digest
// packed {D,C,B,A} and compares the finished entry against a reference digest.
module md5_hex_parser #(
   parameter int unsigned NCHARS = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [7:0]   ascii,
   input  logic         ascii_valid,
   input  logic [127:0] ref_digest,
   output logic         ready,
   output logic [127:0] digest,
   output logic [5:0]   nibble_count,
   output logic         digest_valid,
   output logic         match,
   output logic         err,
   output logic [1:0]   err_code
);

   localparam int unsigned DW = 128;
   localparam int unsigned CW = 6;
   localparam int unsigned NW = 4;
   localparam logic [CW-1:0] FULL_CNT = CW'(NCHARS);

   localparam logic [1:0] ERR_BAD   = 2'd1;
   localparam logic [1:0] ERR_OVF   = 2'd2;
   localparam logic [1:0] ERR_SHORT = 2'd3;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      FULL    = 2'd1,
      REPORT  = 2'd2
   } state_t;

   state_t          r_state;
   logic [DW-1:0]   r_digest;
   logic [CW-1:0]   r_count;
   logic            r_ready;
   logic            r_dv;
   logic            r_match;
   logic            r_err;
   logic [1:0]      r_err_code;

   state_t          w_state_nxt;
   logic [DW-1:0]   w_digest_nxt;
   logic [CW-1:0]   w_count_nxt;
   logic            w_dv_nxt;
   logic            w_match_nxt;
   logic            w_err_nxt;
   logic [1:0]      w_err_code_nxt;

   logic            w_is_hex;
   logic            w_is_bs;
   logic            w_is_enter;
   logic            w_is_nul;
   logic            w_is_bad;
   logic [NW-1:0]   w_nib;
   logic [4:0]      w_prev_pos;
   logic [4:0]      w_wr_idx;
   logic [4:0]      w_bs_idx;

   // Classify the incoming character and convert hex digits to a nibble
   always_comb begin
      w_is_hex   = 1'b0;
      w_nib      = '0;
      w_is_bs    = (ascii == 8'h08);
      w_is_enter = (ascii == 8'h0d);
      w_is_nul   = (ascii == 8'h00);
      if (ascii >= 8'h30 && ascii <= 8'h39) begin
         w_is_hex = 1'b1;
         w_nib    = ascii[3:0];
      end else if ((ascii >= 8'h61 && ascii <= 8'h66) ||
                   (ascii >= 8'h41 && ascii <= 8'h46)) begin
         w_is_hex = 1'b1;
         w_nib    = 4'(ascii[3:0] + 4'd9);
      end
      w_is_bad = !(w_is_hex || w_is_bs || w_is_enter || w_is_nul);
   end

   // Nibble slot for digit k: byte k/2, high nibble first within each byte
   always_comb begin
      w_prev_pos = 5'(r_count - CW'(1));
      w_wr_idx   = {r_count[4:1], ~r_count[0]};
      w_bs_idx   = {w_prev_pos[4:1], ~w_prev_pos[0]};
   end

   // Next-state and registered-output logic
   always_comb begin
      w_state_nxt    = r_state;
      w_digest_nxt   = r_digest;
      w_count_nxt    = r_count;
      w_dv_nxt       = 1'b0;
      w_match_nxt    = 1'b0;
      w_err_nxt      = 1'b0;
      w_err_code_nxt = 2'd0;
      unique case (r_state)
         COLLECT: begin
            if (ascii_valid) begin
               if (w_is_hex) begin
                  w_digest_nxt[{w_wr_idx, 2'b00} +: NW] = w_nib;
                  w_count_nxt = r_count + CW'(1);
                  if (w_count_nxt == FULL_CNT) w_state_nxt = FULL;
               end else if (w_is_bs) begin
                  if (r_count != '0) begin
                     w_digest_nxt[{w_bs_idx, 2'b00} +: NW] = '0;
                     w_count_nxt = r_count - CW'(1);
                  end
               end else if (w_is_enter) begin
                  w_err_nxt      = 1'b1;
                  w_err_code_nxt = ERR_SHORT;
               end else if (w_is_bad) begin
                  w_err_nxt      = 1'b1;
                  w_err_code_nxt = ERR_BAD;
               end
            end
         end
         FULL: begin
            if (ascii_valid) begin
               if (w_is_hex) begin
                  w_err_nxt      = 1'b1;
                  w_err_code_nxt = ERR_OVF;
               end else if (w_is_bs) begin
                  w_digest_nxt[{w_bs_idx, 2'b00} +: NW] = '0;
                  w_count_nxt = r_count - CW'(1);
                  w_state_nxt = COLLECT;
               end else if (w_is_enter) begin
                  w_state_nxt = REPORT;
               end else if (w_is_bad) begin
                  w_err_nxt      = 1'b1;
                  w_err_code_nxt = ERR_BAD;
               end
            end
         end
         REPORT: begin
            // Strobes are dropped here; the entry is judged and cleared
            w_dv_nxt     = 1'b1;
            w_match_nxt  = (r_digest == ref_digest);
            w_digest_nxt = '0;
            w_count_nxt  = '0;
            w_state_nxt  = COLLECT;
         end
         default: w_state_nxt = COLLECT;
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= COLLECT;
         r_digest   <= '0;
         r_count    <= '0;
         r_ready    <= 1'b1;
         r_dv       <= 1'b0;
         r_match    <= 1'b0;
         r_err      <= 1'b0;
         r_err_code <= 2'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_digest   <= w_digest_nxt;
         r_count    <= w_count_nxt;
         r_ready    <= (w_state_nxt != REPORT);
         r_dv       <= w_dv_nxt;
         r_match    <= w_match_nxt;
         r_err      <= w_err_nxt;
         r_err_code <= w_err_code_nxt;
      end
   end

   assign ready        = r_ready;
   assign digest       = r_digest;
   assign nibble_count = r_count;
   assign digest_valid = r_dv;
   assign match        = r_match;
   assign err          = r_err;
   assign err_code     = r_err_code;

endmodule

// File: tb/tb_md5_hex_parser.sv
// Scoreboard bench for md5_hex_parser: expected err/digest_valid events are
// queued by the stimulus and popped by an independent monitor.
module tb_md5_hex_parser;

   logic         clk;
   logic         reset;
   logic [7:0]   ascii;
   logic         ascii_valid;
   logic [127:0] ref_digest;
   logic         ready;
   logic [127:0] digest;
   logic [5:0]   nibble_count;
   logic         digest_valid;
   logic         match;
   logic         err;
   logic [1:0]   err_code;

   typedef struct packed {
      logic       dv;
      logic       m;
      logic [1:0] code;
   } ev_t;

   ev_t exp_q[$];
   int  n_cmp = 0;
   int  n_bad = 0;

   localparam logic [127:0] EMPTY_MD5 = 128'h7e42f8ec_980980e9_04b2008f_d98c1dd4;
   localparam string        EMPTY_STR = "d41d8cd98f00b204e9800998ecf8427e";

   md5_hex_parser #(.NCHARS(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .ascii        (ascii),
      .ascii_valid  (ascii_valid),
      .ref_digest   (ref_digest),
      .ready        (ready),
      .digest       (digest),
      .nibble_count (nibble_count),
      .digest_valid (digest_valid),
      .match        (match),
      .err          (err),
      .err_code     (err_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_err(input logic [1:0] code);
      ev_t e;
      e.dv = 1'b0; e.m = 1'b0; e.code = code;
      exp_q.push_back(e);
   endtask

   task automatic push_dv(input logic m);
      ev_t e;
      e.dv = 1'b1; e.m = m; e.code = 2'd0;
      exp_q.push_back(e);
   endtask

   // Monitor: every err/digest_valid pulse must match the oldest expected event
   always @(negedge clk) begin
      if (err || digest_valid) begin
         ev_t e;
         logic [4:0] act_v, exp_v;
         act_v = {digest_valid, match, err, err_code};
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_event: got dv/m/err/code=%b expected none", act_v);
         end else begin
            e = exp_q.pop_front();
            exp_v = e.dv ? {1'b1, e.m, 1'b0, 2'd0} : {1'b0, 1'b0, 1'b1, e.code};
            n_cmp++;
            if (act_v !== exp_v) begin
               n_bad++;
               $display("FAIL event: got dv/m/err/code=%b expected %b", act_v, exp_v);
            end
         end
      end
   end

   // One-cycle strobe, launched and retired on falling edges
   task automatic send(input logic [7:0] c);
      ascii       = c;
      ascii_valid = 1'b1;
      @(negedge clk);
      ascii_valid = 1'b0;
      ascii       = 8'h00;
   endtask

   task automatic type_str(input string s, input int n, input bit upper);
      logic [7:0] c;
      for (int i = 0; i < n; i++) begin
         c = s[i];
         if (upper && c >= 8'h61 && c <= 8'h66) c = c - 8'h20;
         send(c);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] exp_d;
      reset       = 1'b1;
      ascii       = 8'h00;
      ascii_valid = 1'b0;
      ref_digest  = '0;
      repeat (2) @(negedge clk);
      chk("rst_digest", digest, '0);
      chk("rst_count", 128'(nibble_count), 128'd0);
      chk("rst_ready", 128'(ready), 128'd1);
      chk("rst_pulses", 128'({digest_valid, match, err, err_code}), 128'd0);
      reset = 1'b0;
      @(negedge clk);

      // Empty-message digest, lowercase; ref changes before Enter are irrelevant
      ref_digest = ~EMPTY_MD5;
      type_str(EMPTY_STR, 32, 1'b0);
      chk("lc_count32", 128'(nibble_count), 128'd32);
      chk("lc_digest", digest, EMPTY_MD5);
      ref_digest = EMPTY_MD5;
      push_dv(1'b1);
      send(8'h0d);
      chk("report_ready", 128'(ready), 128'd0);
      send(8'h31);   // dropped: lands on the REPORT cycle
      chk("post_count", 128'(nibble_count), 128'd0);
      chk("post_digest", digest, '0);
      @(negedge clk);
      chk("post2_count", 128'(nibble_count), 128'd0);

      // Uppercase entry, reference with bit 0 flipped
      type_str(EMPTY_STR, 32, 1'b1);
      chk("uc_digest", digest, EMPTY_MD5);
      ref_digest = EMPTY_MD5 ^ 128'd1;
      push_dv(1'b0);
      send(8'h0d);
      @(negedge clk);
      chk("uc_clear", 128'(nibble_count), 128'd0);

      // "12", backspace, "f", Enter (short)
      send(8'h31); send(8'h32); send(8'h08); send(8'h66);
      chk("bs_digest", digest, 128'h1f);
      chk("bs_count", 128'(nibble_count), 128'd2);
      push_err(2'd3);
      send(8'h0d);
      chk("short_keep", digest, 128'h1f);
      send(8'h08); send(8'h08);
      chk("bs_to_zero", digest, '0);

      // Backspace at zero, NUL, bad character
      send(8'h08);
      send(8'h00);
      chk("bs0_count", 128'(nibble_count), 128'd0);
      push_err(2'd1);
      send(8'h67);
      chk("bad_count", 128'(nibble_count), 128'd0);
      chk("bad_digest", digest, '0);

      // Overflow, bad char in FULL, then backspace out of FULL
      type_str(EMPTY_STR, 32, 1'b0);
      push_err(2'd2);
      send(8'h35);
      chk("ovf_digest", digest, EMPTY_MD5);
      push_err(2'd1);
      send(8'h7a);
      chk("fullbad_count", 128'(nibble_count), 128'd32);
      send(8'h08);
      chk("full_bs_count", 128'(nibble_count), 128'd31);
      exp_d = EMPTY_MD5 & ~(128'hf << 120);
      chk("full_bs_digest", digest, exp_d);
      send(8'h65);
      ref_digest = EMPTY_MD5;
      push_dv(1'b1);
      send(8'h0d);
      @(negedge clk);

      // Reset mid-entry with a strobe present
      type_str(EMPTY_STR, 17, 1'b0);
      chk("mid_count", 128'(nibble_count), 128'd17);
      reset = 1'b1; ascii = 8'h61; ascii_valid = 1'b1;
      @(negedge clk);
      reset = 1'b0; ascii_valid = 1'b0; ascii = 8'h00;
      chk("mr_digest", digest, '0);
      chk("mr_count", 128'(nibble_count), 128'd0);
      chk("mr_ready", 128'(ready), 128'd1);

      // Reset during REPORT suppresses digest_valid
      type_str(EMPTY_STR, 32, 1'b0);
      send(8'h0d);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rr_count", 128'(nibble_count), 128'd0);
      chk("rr_ready", 128'(ready), 128'd1);

      repeat (3) @(negedge clk);
      chk("queue_empty", 128'(exp_q.size()), 128'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
